// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and response bundle for alu_op_sequencer.
// ALU_SEQ_CHECK_EN adds the out_err response flag.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OPW-1:0]   in_op;
  logic             in_sweep;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_sel;
  logic [WIDTH-1:0] alu_y;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [OPW-1:0]   out_op;
  logic             out_last;
  logic             busy;

`ifdef ALU_SEQ_CHECK_EN
  logic             out_err;

  modport master (
    output in_valid, in_a, in_b, in_op, in_sweep,
    output alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel,
    input  out_valid, out_y, out_op, out_last,
    input  busy, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_sweep,
    input  alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_sel,
    output out_valid, out_y, out_op, out_last,
    output busy, out_err
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_op, in_sweep,
    output alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel,
    input  out_valid, out_y, out_op, out_last,
    input  busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_sweep,
    input  alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_sel,
    output out_valid, out_y, out_op, out_last,
    output busy
  );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives an external ALU one opcode (or an 8-op sweep) per command.
// ALU_SEQ_CHECK_EN adds a reference model and the out_err flag.
module alu_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input logic                clk,
  input logic                rst,
  alu_op_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [OPW-1:0] SEL_MAX = '1;

  state_t           state;
  state_t           nxt;
  logic             sweep;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   sel_q;
  logic [WIDTH-1:0] y_q;
  logic [OPW-1:0]   op_q;
  logic             last_q;
  logic             accept;
  logic             done;

  assign accept = bus.in_valid & (state == IDLE);
  assign done   = bus.out_ready & (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = ISSUE;
      ISSUE:   nxt = RESP;
      RESP:    if (done) nxt = last_q ? IDLE : ISSUE;
      default: nxt = IDLE;
    endcase
  end

  // Sel only advances on a non-final handshake, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= '0;
      sweep  <= 1'b0;
      y_q    <= '0;
      op_q   <= '0;
      last_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= bus.in_a;
        b_q   <= bus.in_b;
        sel_q <= bus.in_sweep ? '0 : bus.in_op;
        sweep <= bus.in_sweep;
      end
      if (state == ISSUE) begin
        y_q    <= bus.alu_y;
        op_q   <= sel_q;
        last_q <= !sweep || (sel_q == SEL_MAX);
      end
      if (done && !last_q) sel_q <= sel_q + 1'b1;
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [WIDTH-1:0] ref_y;
  logic             err_q;

  always_comb begin
    ref_y = '0;
    unique case (sel_q)
      3'd0:    ref_y = a_q + b_q;
      3'd1:    ref_y = a_q - b_q;
      3'd2:    ref_y = a_q & b_q;
      3'd3:    ref_y = ~(a_q | b_q);
      3'd4:    ref_y = ~(a_q ^ b_q);
      3'd5:    ref_y = a_q ^ b_q;
      3'd6:    ref_y = a_q | b_q;
      3'd7:    ref_y = ~(a_q & b_q);
      default: ref_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 err_q <= 1'b0;
    else if (state == ISSUE) err_q <= (bus.alu_y != ref_y);
  end

  assign bus.out_err = err_q;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == RESP);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_sel   = sel_q;
  assign bus.out_y     = y_q;
  assign bus.out_op    = op_q;
  assign bus.out_last  = last_q;

endmodule
